// File: rtl/fir_pkg.sv
// fir_pkg: state type, default sizes and arithmetic helpers for fir_tdm.
// fir_round/fir_ovf serve the FIR_SATURATE_EN output stage.
package fir_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_NUM_TAPS = 8;
  localparam int DEF_NUM_CH   = 2;
  localparam int ACC_MAX      = 128;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SCALE,
    OUT
  } fir_state_e;

  function automatic int fir_acc_w(
    input int dw,
    input int cw,
    input int nt
  );
    return dw + cw + $clog2(nt);
  endfunction

  // Round half-up, then drop the Q1.(cw-1) fraction.
  function automatic logic signed [ACC_MAX-1:0] fir_round(
    input logic signed [ACC_MAX-1:0] v,
    input int                        cw
  );
    logic signed [ACC_MAX-1:0] half;
    half = ACC_MAX'(1) << (cw - 2);
    return (v + half) >>> (cw - 1);
  endfunction

  function automatic logic fir_ovf(
    input logic signed [ACC_MAX-1:0] v,
    input int                        dw
  );
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    hi = (ACC_MAX'(1) << (dw - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: single signed multiply-accumulate shared by all taps and
// channels; clr wins over en.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = fir_acc_w(DEF_DATA_W, DEF_COEF_W, DEF_NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DATA_W+COEF_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed multi-channel FIR, one tap per cycle.
// Define FIR_SATURATE_EN for a rounded, clipped output with out_sat.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int NUM_CH   = DEF_NUM_CH,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W  = $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_sat
);

  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

  fir_state_e state;
  fir_state_e state_nx;

  logic [ADDR_W-1:0]        tap;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] x [NUM_CH][NUM_TAPS];
  logic signed [COEF_W-1:0] h [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] res;
  logic                     res_sat;
  logic                     ch_ok;
  logic                     start;
  logic                     coef_ok;

  assign ch_ok   = int'(in_ch) < NUM_CH;
  assign start   = in_valid && in_ready && ch_ok;
  assign coef_ok = coef_we && (state == IDLE)
                && (int'(coef_addr) < NUM_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (tap == LAST) state_nx = SCALE;
      SCALE:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      state == IDLE: in_ready  = 1'b1;
      state == OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap  <= '0;
      ch_q <= '0;
    end else if (start) begin
      tap  <= '0;
      ch_q <= in_ch;
    end else if (state == MAC) begin
      tap <= tap + 1'b1;
    end
  end

  // Only the addressed channel shifts; invalid channels never reach here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          x[c][k] <= '0;
        end
      end
    end else if (start) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c == int'(in_ch)) begin
          x[c][0] <= in_data;
          for (int k = 1; k < NUM_TAPS; k++) begin
            x[c][k] <= x[c][k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        h[k] <= '0;
      end
      h[0] <= {1'b0, {(COEF_W-1){1'b1}}};
    end else if (coef_ok) begin
      h[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (state == MAC),
    .a   (x[ch_q][tap]),
    .b   (h[tap]),
    .acc (acc)
  );

`ifdef FIR_SATURATE_EN
  logic signed [ACC_MAX-1:0] rnd;

  assign rnd = fir_round(ACC_MAX'(acc), COEF_W);

  always_comb begin
    res_sat = fir_ovf(rnd, DATA_W);
    res     = rnd[DATA_W-1:0];
    if (res_sat) begin
      res = rnd[ACC_MAX-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                           : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign res     = DATA_W'(acc >>> (COEF_W - 1));
  assign res_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ch   <= '0;
      out_sat  <= 1'b0;
    end else if (state == SCALE) begin
      out_data <= res;
      out_ch   <= ch_q;
      out_sat  <= res_sat;
    end
  end

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: directed and random checks of fir_tdm against an arithmetic
// model; NUM_CH=3 so that channel 3 is an invalid channel.
module tb_fir_tdm;

  localparam int NT  = 8;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_ch = '0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_sat;

  int xm [NCH][NT];
  int hm [NT];
  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_d;
  logic [1:0]  exp_ch;
  logic        exp_s;

  fir_tdm #(
    .DATA_W   (16),
    .COEF_W   (16),
    .NUM_TAPS (NT),
    .NUM_CH   (NCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NT; k++) xm[c][k] = 0;
    for (int k = 0; k < NT; k++) hm[k] = 0;
    hm[0] = 32767;
  endfunction

  // Dot product of delay line and taps, then the output scaling rule.
  function automatic void model_calc(input int ch);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < NT; k++)
      acc += longint'(xm[ch][k]) * longint'(hm[k]);
`ifdef FIR_SATURATE_EN
    r = (acc + 64'sd16384) >>> 15;
    exp_s = (r > 32767) || (r < -32768);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    r = acc >>> 15;
    exp_s = 1'b0;
`endif
    exp_d  = r[15:0];
    exp_ch = ch[1:0];
  endfunction

  task automatic send(input int ch, input logic [15:0] d, input bit cw,
                      input int ca, input logic [15:0] cd);
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_ch     = ch[1:0];
    coef_we   = cw;
    coef_addr = ca[2:0];
    coef_data = cd;
    @(posedge clk);
    if (cw) hm[ca] = int'($signed(cd));
    if (ch < NCH) begin
      for (int k = NT - 1; k > 0; k--) xm[ch][k] = xm[ch][k-1];
      xm[ch][0] = int'($signed(d));
      model_calc(ch);
    end
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int pre);
    int n;
    n = pre;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, NT + 1);
    chk({tag, "_data"}, {16'b0, out_data}, {16'b0, exp_d});
    chk({tag, "_ch"}, {30'b0, out_ch}, {30'b0, exp_ch});
    chk({tag, "_sat"}, {31'b0, out_sat}, {31'b0, exp_s});
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_idle"}, {30'b0, out_valid, in_ready}, 32'b01);
    end
  endtask

  task automatic expect_none(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic write_coef(input int a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a[2:0];
    coef_data = d;
    @(posedge clk);
    hm[a] = int'($signed(d));
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  initial begin
    int          bad;
    int          rch;
    int          rca;
    bit          rcw;
    logic [15:0] rd;
    logic [15:0] rcd;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {16'b0, out_data}, 0);
    chk("rst_out_ch", {30'b0, out_ch}, 0);
    chk("rst_out_sat", {31'b0, out_sat}, 0);

    send(0, 16'h4000, 0, 0, 16'h0);
    wait_out("unit", 0);

    for (int k = 0; k < NT; k++) write_coef(k, 16'h1000);
    repeat (NT) begin
      send(0, 16'h7FFF, 0, 0, 16'h0);
      wait_out("avg", 0);
    end
    for (int k = 0; k < NT; k++) write_coef(k, 16'h7FFF);
    repeat (NT) begin
      send(0, 16'h7FFF, 0, 0, 16'h0);
      wait_out("big", 0);
    end

    for (int k = 0; k < NT; k++) write_coef(k, 16'h1000);
    repeat (NT) begin
      send(0, 16'h7FFF, 0, 0, 16'h0);
      wait_out("il0", 0);
      chk("il0_pos", {31'b0, out_data[15]}, 0);
      send(1, 16'h8000, 0, 0, 16'h0);
      wait_out("il1", 0);
      chk("il1_neg", {31'b0, out_data[15]}, 1);
    end

    out_ready = 1'b0;
    send(2, 16'h2345, 0, 0, 16'h0);
    wait_out("hold", 0);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if ({out_valid, in_ready} !== 2'b10) bad++;
      if ({out_data, out_ch, out_sat} !== {exp_d, exp_ch, exp_s}) bad++;
    end
    chk("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release", {30'b0, out_valid, in_ready}, 32'b01);

    send(1, 16'h1234, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    expect_none("abort_none", NT + 6);
    chk("abort_state",
        {11'b0, in_ready, out_valid, out_data, out_ch, out_sat},
        {11'b0, 1'b1, 1'b0, 16'h0, 2'b0, 1'b0});
    send(0, 16'h2000, 0, 0, 16'h0);
    wait_out("rst_h", 0);
    for (int k = 0; k < NT; k++) write_coef(k, 16'h1000);
    send(0, 16'h2000, 0, 0, 16'h0);
    wait_out("rst_x", 0);

    send(0, 16'h1111, 0, 0, 16'h0);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    wait_out("macw", 1);
    send(3, 16'h5555, 0, 0, 16'h0);
    chk("drop_ready", {31'b0, in_ready}, 1);
    expect_none("drop_none", NT + 4);
    send(0, 16'h0100, 0, 0, 16'h0);
    wait_out("post_drop", 0);

    repeat (3) begin
      send(1, 16'h3000, 0, 0, 16'h0);
      wait_out("pre_sim", 0);
    end
    send(1, 16'h4000, 1, 3, 16'h7000);
    wait_out("simul", 0);

    for (int i = 0; i < 40; i++) begin
      rch = int'($urandom_range(0, 3));
      rcw = ($urandom_range(0, 3) == 0);
      rca = int'($urandom_range(0, NT - 1));
      rd  = 16'($urandom);
      rcd = 16'($urandom);
      send(rch, rd, rcw, rca, rcd);
      if (rch < NCH) wait_out("rand", 0);
      else expect_none("rand_drop", 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
